// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers: S-box table,
// GF(2^8) doubling and the round-constant sequence.
package aes_pkg;

    typedef logic [7:0]              byte_t;
    typedef logic [31:0]             word_t;
    typedef byte_t [0:3][0:3]        state_t;

    localparam int         NR         = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) with reduction polynomial 0x11b.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for rounds 1..NR; zero outside that range (idle).
    function automatic byte_t rcon_for(input logic [3:0] round);
        if (round >= 4'd1 && round <= LAST_ROUND)
            return RCON[round - 4'd1];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-schedule step: derives K(r) from K(r-1).
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);
    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_rot, w_sub;
    word_t w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = rk_in[127:96];
    assign w_w1  = rk_in[95:64];
    assign w_w2  = rk_in[63:32];
    assign w_w3  = rk_in[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // Four dedicated S-boxes for SubWord so the key path never shares the state S-boxes.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_subword
        assign w_sub[31-8*gi -: 8] = SBOX[w_rot[31-8*gi -: 8]];
    end

    assign w_n0   = w_w0 ^ w_sub ^ {rcon, 24'h000000};
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign rk_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly.
// Optional macro AES128_LAST_KEY_OUT_EN exposes the final round key K(10)
// on last_round_key as the starting key for a companion decryptor.
module aes128_encrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
`ifdef AES128_LAST_KEY_OUT_EN
    ,
    output logic [127:0] last_round_key
`endif
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   r_fsm;
    logic [3:0]   r_round;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [127:0] r_ciphertext;
    logic         r_done;
`ifdef AES128_LAST_KEY_OUT_EN
    logic [127:0] r_last_key;
`endif

    logic [127:0] w_rk_next;
    logic [127:0] w_next_state;
    logic         w_last;
    byte_t        w_sb [0:15];
    byte_t        w_sr [0:15];
    byte_t        w_mc [0:15];

    assign w_last = (r_round == LAST_ROUND);

    aes_key_step u_key_step (
        .rk_in  (r_rk),
        .rcon   (rcon_for(r_round)),
        .rk_out (w_rk_next)
    );

    genvar gi;
    // SubBytes then ShiftRows: output byte 4c+r takes input byte 4((c+r)%4)+r.
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
        assign w_sb[gi] = SBOX[r_state[127-8*gi -: 8]];
        assign w_sr[gi] = w_sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    end

    // MixColumns on each column of the shifted state.
    for (gi = 0; gi < 4; gi++) begin : g_mix
        byte_t w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[4*gi+0];
        assign w_a1 = w_sr[4*gi+1];
        assign w_a2 = w_sr[4*gi+2];
        assign w_a3 = w_sr[4*gi+3];
        assign w_mc[4*gi+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[4*gi+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[4*gi+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mc[4*gi+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    // AddRoundKey; the final round bypasses MixColumns.
    for (gi = 0; gi < 16; gi++) begin : g_add_key
        assign w_next_state[127-8*gi -: 8] =
            (w_last ? w_sr[gi] : w_mc[gi]) ^ w_rk_next[127-8*gi -: 8];
    end

    // Control FSM, round counter, state/key registers and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= ST_IDLE;
            r_round      <= 4'd0;
            r_state      <= '0;
            r_rk         <= '0;
            r_ciphertext <= '0;
            r_done       <= 1'b0;
`ifdef AES128_LAST_KEY_OUT_EN
            r_last_key   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= plaintext ^ key;
                        r_rk    <= key;
                        r_round <= 4'd1;
                        r_fsm   <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= w_next_state;
                    r_rk    <= w_rk_next;
                    if (w_last) begin
                        r_ciphertext <= w_next_state;
                        r_done       <= 1'b1;
                        r_round      <= 4'd0;
                        r_fsm        <= ST_IDLE;
`ifdef AES128_LAST_KEY_OUT_EN
                        r_last_key   <= w_rk_next;
`endif
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
            endcase
        end
    end

    assign busy       = (r_fsm == ST_RUN);
    assign done       = r_done;
    assign ciphertext = r_ciphertext;
`ifdef AES128_LAST_KEY_OUT_EN
    assign last_round_key = r_last_key;
`endif

endmodule

// File: tb/tb_aes128_encrypt.sv
// Self-checking bench for aes128_encrypt. The reference AES model derives its
// S-box from GF(2^8) inversion plus the affine map and expands the whole key
// schedule up front.
module tb_aes128_encrypt;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
`ifdef AES128_LAST_KEY_OUT_EN
    logic [127:0] last_round_key;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_ref [256];

    aes128_encrypt dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .plaintext      (plaintext),
        .key            (key_in),
        .busy           (busy),
        .done           (done),
        .ciphertext     (ciphertext)
`ifdef AES128_LAST_KEY_OUT_EN
        ,
        .last_round_key (last_round_key)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic void ref_encrypt(input logic [127:0] pt, input logic [127:0] k,
                                        output logic [127:0] ct, output logic [127:0] k10);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc = 8'h01;
        logic [7:0] x;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x = tmp[0];
                tmp[0] = sbox_ref[tmp[1]] ^ rc;
                tmp[1] = sbox_ref[tmp[2]];
                tmp[2] = sbox_ref[tmp[3]];
                tmp[3] = sbox_ref[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sbox_ref[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) begin
            ct[127-8*i -: 8]  = s[i];
            k10[127-8*i -: 8] = w[160+i];
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue one block and follow it to completion. lat is the number of edges
    // after the start edge at which done is first seen (-1 on timeout).
    task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] lk,
                             output int lat, output int busy_cycles, output logic done_after);
        ct = '0; lk = '0; lat = -1; busy_cycles = 0; done_after = 1'b1;
        @(posedge clk); #1;
        plaintext = pt; key_in = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; plaintext = rnd128(); key_in = rnd128();
        if (busy) busy_cycles++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                ct  = ciphertext;
`ifdef AES128_LAST_KEY_OUT_EN
                lk  = last_round_key;
`endif
                break;
            end
            if (busy) busy_cycles++;
        end
        @(posedge clk); #1;
        done_after = done;
        if (ciphertext !== ct) done_after = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; plaintext = '0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b ct=%h, want 0/0/0", busy, done, ciphertext);
        end
`ifdef AES128_LAST_KEY_OUT_EN
        checks++;
        if (last_round_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_last_key: got %h want 0", last_round_key);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_vector(input string name, input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] exp_ct, input logic [127:0] exp_lk, input bit chk_lk);
        logic [127:0] ct, lk;
        int lat, bc;
        logic da;
        run_block(pt, k, ct, lk, lat, bc, da);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL %s_latency: got %0d edges want 10", name, lat); end
        checks++;
        if (ct !== exp_ct) begin errors++; $display("FAIL %s_ct: got %h want %h", name, ct, exp_ct); end
        checks++;
        if (bc !== 10) begin errors++; $display("FAIL %s_busy_cycles: got %0d want 10", name, bc); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: done/ct after pulse changed, got %b want 0", name, da); end
`ifdef AES128_LAST_KEY_OUT_EN
        if (chk_lk) begin
            checks++;
            if (lk !== exp_lk) begin errors++; $display("FAIL %s_last_key: got %h want %h", name, lk, exp_lk); end
        end
`endif
        $display("%s: pt=%h key=%h ct=%h lat=%0d", name, pt, k, ct, lat);
    endtask

    task automatic test_fips();
        logic [127:0] m_ct, m_lk;
        test_vector("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h0, 1'b0);
        test_vector("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        ref_encrypt(128'h0123456789abcdeffedcba9876543210, 128'h000102030405060708090a0b0c0d0e0f, m_ct, m_lk);
        test_vector("model_vec", 128'h0123456789abcdeffedcba9876543210, 128'h000102030405060708090a0b0c0d0e0f,
                    m_ct, m_lk, 1'b1);
    endtask

    task automatic test_random();
        logic [127:0] pt, k, ct, lk, m_ct, m_lk;
        int lat, bc;
        logic da;
        for (int n = 0; n < 200; n++) begin
            pt = rnd128(); k = rnd128();
            ref_encrypt(pt, k, m_ct, m_lk);
            run_block(pt, k, ct, lk, lat, bc, da);
            checks++;
            if (ct !== m_ct || lat !== 10) begin
                errors++;
                $display("FAIL random_%0d: ct=%h lat=%0d want ct=%h lat=10", n, ct, lat, m_ct);
            end
`ifdef AES128_LAST_KEY_OUT_EN
            checks++;
            if (lk !== m_lk) begin errors++; $display("FAIL random_%0d_last_key: got %h want %h", n, lk, m_lk); end
`endif
            $display("random %0d: pt=%h key=%h ct=%h", n, pt, k, ct);
        end
    endtask

    task automatic test_ignore_start();
        logic [127:0] pt, k, m_ct, m_lk;
        int n_done = 0;
        pt = rnd128(); k = rnd128();
        ref_encrypt(pt, k, m_ct, m_lk);
        @(posedge clk); #1;
        plaintext = pt; key_in = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            plaintext = rnd128(); key_in = rnd128();
            start = (i == 3 || i == 6);
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                checks++;
                if (i !== 10 || ciphertext !== m_ct) begin
                    errors++;
                    $display("FAIL ignore_start_result: edge %0d ct=%h want edge 10 ct=%h", i, ciphertext, m_ct);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL ignore_start_done_count: got %0d want 1", n_done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle: busy=%b want 0", busy); end
        $display("ignore_start: pt=%h key=%h dones=%0d ct=%h", pt, k, n_done, ciphertext);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [45];
        logic [127:0] keys [45];
        logic [127:0] m_ct, m_lk;
        logic exp_done;
        int n_done = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 45; k++) begin
            pts[k] = rnd128(); keys[k] = rnd128();
            plaintext = pts[k]; key_in = keys[k]; start = (k < 30);
            @(posedge clk); #1;
            // Accepts at edges 0, 11, 22 while start is held; each completes 10 edges later.
            exp_done = (k % 11 == 10) && (k - 10 < 30);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done_edge_%0d: got %b want %b", k, done, exp_done);
            end
            if (done) n_done++;
            if (exp_done) begin
                ref_encrypt(pts[k-10], keys[k-10], m_ct, m_lk);
                checks++;
                if (ciphertext !== m_ct) begin
                    errors++;
                    $display("FAIL b2b_ct_edge_%0d: got %h want %h", k, ciphertext, m_ct);
                end
                $display("b2b: accepted edge %0d pt=%h ct=%h", k - 10, pts[k-10], ciphertext);
            end
        end
        start = 1'b0;
        checks++;
        if (n_done !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt, k, ct, lk, m_ct, m_lk;
        int lat, bc;
        logic da;
        int stale = 0;
        @(posedge clk); #1;
        plaintext = rnd128(); key_in = rnd128(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b done=%b ct=%h want 0/0/0", busy, done, ciphertext);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ciphertext !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid_held: busy=%b done=%b ct=%h want 0/0/0", busy, done, ciphertext);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) stale++;
        end
        checks++;
        if (stale !== 0) begin errors++; $display("FAIL reset_mid_stale: %0d busy/done cycles want 0", stale); end
        pt = rnd128(); k = rnd128();
        ref_encrypt(pt, k, m_ct, m_lk);
        run_block(pt, k, ct, lk, lat, bc, da);
        checks++;
        if (ct !== m_ct || lat !== 10) begin
            errors++;
            $display("FAIL reset_mid_next: ct=%h lat=%0d want ct=%h lat=10", ct, lat, m_ct);
        end
        $display("reset_mid: next pt=%h key=%h ct=%h", pt, k, ct);
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_fips();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
